// File: rtl/tb4004_pkg.sv
// Shared phase, opcode and width definitions for the fetch/timing stage and the decoder.
package tb4004_pkg;

  localparam int unsigned CYC_W = 3;
  localparam int unsigned NIB_W = 4;
  localparam int unsigned ARG_W = 8;
  localparam int unsigned PC_W  = 12;
  localparam int unsigned CNT_W = 16;

  localparam logic [2:0] CYC_A1 = 3'd0;
  localparam logic [2:0] CYC_A2 = 3'd1;
  localparam logic [2:0] CYC_A3 = 3'd2;
  localparam logic [2:0] CYC_M1 = 3'd3;
  localparam logic [2:0] CYC_M2 = 3'd4;
  localparam logic [2:0] CYC_X1 = 3'd5;
  localparam logic [2:0] CYC_X2 = 3'd6;
  localparam logic [2:0] CYC_X3 = 3'd7;

  localparam logic [3:0] OPR_JCN     = 4'h1;
  localparam logic [3:0] OPR_FIM_SRC = 4'h2;
  localparam logic [3:0] OPR_JUN     = 4'h4;
  localparam logic [3:0] OPR_JMS     = 4'h5;
  localparam logic [3:0] OPR_ISZ     = 4'h7;

  // FIM and SRC share OPR 0x2; only FIM (opa[0]=0) carries a second byte.
  function automatic logic is_two_word(input logic [3:0] opr, input logic [3:0] opa);
    logic two;
    case (opr)
      OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: two = 1'b1;
      OPR_FIM_SRC:                        two = ((opa & 4'h1) == 4'h0);
      default:                            two = 1'b0;
    endcase
    return two;
  endfunction

endpackage

// File: rtl/fetch_timing_unit_if.sv
// ROM bus and decoder-facing signals of the fetch/timing stage.
interface fetch_timing_unit_if;
  import tb4004_pkg::*;

  logic [NIB_W-1:0] rom_addr;
  logic [NIB_W-1:0] rom_data;
  logic             pc_load;
  logic [PC_W-1:0]  pc_load_val;
  logic             sync;
  logic [CYC_W-1:0] cycle;
  logic [NIB_W-1:0] opr;
  logic [NIB_W-1:0] opa;
  logic             second_word;
  logic [ARG_W-1:0] arg;
  logic [PC_W-1:0]  pc;

  modport master (
    output rom_addr, sync, cycle, opr, opa, second_word, arg, pc,
    input  rom_data, pc_load, pc_load_val
  );

  modport slave (
    input  rom_addr, sync, cycle, opr, opa, second_word, arg, pc,
    output rom_data, pc_load, pc_load_val
  );
endinterface

// File: rtl/cycle_counter.sv
// 8-phase machine-cycle counter with run enable; sync is registered high throughout X3.
module cycle_counter
  import tb4004_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic [CYC_W-1:0] cycle,
  output logic             sync
);

  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             sync_q, sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q  <= CYC_A1;
      sync_q <= 1'b0;
    end else begin
      cyc_q  <= cyc_d;
      sync_q <= sync_d;
    end
  end

  // Natural 3-bit wrap takes X3 back to A1.
  always_comb begin
    cyc_d  = cyc_q;
    sync_d = sync_q;
    if (run) begin
      cyc_d  = cyc_q + CYC_W'(1);
      sync_d = (cyc_d == CYC_X3);
    end
  end

  assign cycle = cyc_q;
  assign sync  = sync_q;

endmodule

// File: rtl/fetch_timing_unit.sv
// Instruction fetch and machine-cycle timing stage feeding the decoder.
// Optional FETCH_INSTR_CNT_EN adds a completed-instruction counter output.
module fetch_timing_unit
  import tb4004_pkg::*;
#(
  parameter logic [11:0] PC_RESET = 12'h000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  fetch_timing_unit_if.master    bus
`ifdef FETCH_INSTR_CNT_EN
  ,
  output logic [CNT_W-1:0]       instr_count
`endif
);

  logic [CYC_W-1:0] cyc;
  logic             sync;

  cycle_counter u_cycle_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .cycle (cyc),
    .sync  (sync)
  );

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [NIB_W-1:0] opr_q, opr_d;
  logic [NIB_W-1:0] opa_q, opa_d;
  logic [NIB_W-1:0] hi_q, hi_d;
  logic [ARG_W-1:0] arg_q, arg_d;
  logic             sw_q, sw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= PC_RESET;
      opr_q <= '0;
      opa_q <= '0;
      hi_q  <= '0;
      arg_q <= '0;
      sw_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      opr_q <= opr_d;
      opa_q <= opa_d;
      hi_q  <= hi_d;
      arg_q <= arg_d;
      sw_q  <= sw_d;
      cnt_q <= cnt_d;
    end
  end

  // Phase-driven fetch: high nibble in M1, low nibble and PC step in M2, jump and word tracking in X3.
  always_comb begin
    pc_d  = pc_q;
    opr_d = opr_q;
    opa_d = opa_q;
    hi_d  = hi_q;
    arg_d = arg_q;
    sw_d  = sw_q;
    cnt_d = cnt_q;
    if (run) begin
      case (cyc)
        CYC_M1: hi_d = bus.rom_data;
        CYC_M2: begin
          if (sw_q) begin
            arg_d = {hi_q, bus.rom_data};
          end else begin
            opr_d = hi_q;
            opa_d = bus.rom_data;
          end
          pc_d = pc_q + PC_W'(1);
        end
        CYC_X3: begin
          if (bus.pc_load) pc_d = bus.pc_load_val;
          sw_d = !sw_q && is_two_word(opr_q, opa_q);
          if (!sw_d) cnt_d = cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (cyc)
      CYC_A1:  bus.rom_addr = pc_q[3:0];
      CYC_A2:  bus.rom_addr = pc_q[7:4];
      CYC_A3:  bus.rom_addr = pc_q[11:8];
      default: bus.rom_addr = '0;
    endcase
  end

  assign bus.cycle       = cyc;
  assign bus.sync        = sync;
  assign bus.pc          = pc_q;
  assign bus.opr         = opr_q;
  assign bus.opa         = opa_q;
  assign bus.arg         = arg_q;
  assign bus.second_word = sw_q;

`ifdef FETCH_INSTR_CNT_EN
  assign instr_count = cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = ^cnt_q;
`endif

endmodule
